// File: rtl/arrow_scroll_scheduler.sv
// arrow_scroll_scheduler
// Sequences the two-player arrow playfield. On every scroll step one chart
// code is fetched from the song ROM and pushed into slot 0 of both players'
// 26-slot arrow arrays while every other slot moves one place down the
// screen. Button presses are judged against the hit window near the bottom
// of the screen, and the result drives the indicator codes and the scores.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start               one-cycle pulse, accepted in IDLE or DONE
//   song_addr/song_data chart ROM address and registered ROM data (1-cycle latency)
//   pN_press, pN_code   per-player press strobe and lane code
//   pN_arrow_array      26 x 3-bit slots, slot k = bits [3k+2:3k], slot 0 = top
//   pN_indicator        11 excellent, 10 good, 01 bad/miss, 00 blank
//   pN_score            saturating 16-bit score
//   busy, done          RUN/DRAIN and DONE status flags
module arrow_scroll_scheduler #(
  parameter int STEP_TICKS = 833333,
  parameter int SONG_LEN   = 256,
  parameter int HOLD_STEPS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  song_addr,
  input  logic [2:0]  song_data,
  input  logic        p1_press,
  input  logic [2:0]  p1_code,
  input  logic        p2_press,
  input  logic [2:0]  p2_code,
  output logic [77:0] p1_arrow_array,
  output logic [77:0] p2_arrow_array,
  output logic [1:0]  p1_indicator,
  output logic [1:0]  p2_indicator,
  output logic [15:0] p1_score,
  output logic [15:0] p2_score,
  output logic        busy,
  output logic        done
);

  localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int HW = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DRAIN = 2'b10, DONE = 2'b11} state_t;

  typedef struct packed {
    logic [77:0]   arr;
    logic [1:0]    ind;
    logic [HW-1:0] hold;
    logic [15:0]   score;
  } player_t;

  state_t        state_r, state_s;
  logic [TW-1:0] tick_r;
  logic [8:0]    step_r;
  logic [4:0]    drain_r;
  logic          busy_r, done_r;
  player_t       p1_r, p2_r, p1_s, p2_s;

  logic          active_s, step_s, start_ok_s, last_run_s, last_drain_s;
  logic [2:0]    din_s;

  // Judge a press against the pre-shift array (excellent tier 24,23 then good
  // tier 25,22), clear the matched slot, then apply the scroll shift so a
  // cleared slot moves down with everything else. A press outcome overrides
  // a miss produced by the same step.
  function automatic player_t player_next(input player_t cur, input logic press,
                                          input logic [2:0] code, input logic active,
                                          input logic step, input logic [2:0] din);
    player_t     nx;
    logic [77:0] a;
    logic        judged, miss;
    logic [1:0]  grade, add;
    logic [16:0] sum;
    nx     = cur;
    a      = cur.arr;
    judged = active && press && (code != 3'b000);
    grade  = 2'b01;
    add    = 2'd0;
    miss   = 1'b0;
    if (judged) begin
      if (a[74:72] == code) begin
        a[74:72] = 3'b000; grade = 2'b11; add = 2'd2;
      end else if (a[71:69] == code) begin
        a[71:69] = 3'b000; grade = 2'b11; add = 2'd2;
      end else if (a[77:75] == code) begin
        a[77:75] = 3'b000; grade = 2'b10; add = 2'd1;
      end else if (a[68:66] == code) begin
        a[68:66] = 3'b000; grade = 2'b10; add = 2'd1;
      end else begin
        grade = 2'b01; add = 2'd0;
      end
    end else begin
      grade = 2'b01; add = 2'd0;
    end
    if (step) begin
      miss = (a[77:75] != 3'b000);
      a    = {a[74:0], din};
    end else begin
      miss = 1'b0;
    end
    nx.arr = a;
    sum    = {1'b0, cur.score} + {15'd0, add};
    if (judged) begin
      nx.ind   = grade;
      nx.hold  = HW'(HOLD_STEPS);
      nx.score = sum[16] ? 16'hFFFF : sum[15:0];
    end else if (miss) begin
      nx.ind  = 2'b01;
      nx.hold = HW'(HOLD_STEPS);
    end else if (step && (cur.hold != '0)) begin
      nx.hold = cur.hold - HW'(1);
      nx.ind  = (cur.hold == HW'(1)) ? 2'b00 : cur.ind;
    end else begin
      nx.hold = cur.hold;
    end
    return nx;
  endfunction

  assign active_s     = (state_r == RUN) || (state_r == DRAIN);
  assign step_s       = active_s && (tick_r == TW'(STEP_TICKS - 1));
  assign start_ok_s   = start && ((state_r == IDLE) || (state_r == DONE));
  assign last_run_s   = (step_r == 9'(SONG_LEN - 1));
  assign last_drain_s = (drain_r == 5'd25);
  assign din_s        = (state_r == RUN) ? song_data : 3'b000;

  assign p1_s = player_next(p1_r, p1_press, p1_code, active_s, step_s, din_s);
  assign p2_s = player_next(p2_r, p2_press, p2_code, active_s, step_s, din_s);

  // Next-state logic for the playfield sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) state_s = RUN;
        else       state_s = state_r;
      end
      RUN: begin
        if (step_s && last_run_s) state_s = DRAIN;
        else                      state_s = RUN;
      end
      DRAIN: begin
        if (step_s && last_drain_s) state_s = DONE;
        else                        state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, counters, player registers and status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      tick_r  <= '0;
      step_r  <= 9'd0;
      drain_r <= 5'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      p1_r    <= '0;
      p2_r    <= '0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN) || (state_s == DRAIN);
      done_r  <= (state_s == DONE);
      if (start_ok_s) begin
        tick_r  <= '0;
        step_r  <= 9'd0;
        drain_r <= 5'd0;
        p1_r    <= '0;
        p2_r    <= '0;
      end else if (active_s) begin
        tick_r <= step_s ? '0 : tick_r + TW'(1);
        if (step_s && (state_r == RUN))   step_r  <= step_r + 9'd1;
        if (step_s && (state_r == DRAIN)) drain_r <= drain_r + 5'd1;
        p1_r <= p1_s;
        p2_r <= p2_s;
      end
    end
  end

  assign song_addr      = step_r[7:0];
  assign p1_arrow_array = p1_r.arr;
  assign p2_arrow_array = p2_r.arr;
  assign p1_indicator   = p1_r.ind;
  assign p2_indicator   = p2_r.ind;
  assign p1_score       = p1_r.score;
  assign p2_score       = p2_r.score;
  assign busy           = busy_r;
  assign done           = done_r;

endmodule

// File: tb/tb_arrow_scroll_scheduler.sv
// Self-checking bench for arrow_scroll_scheduler: directed judgment table,
// hand-written multi-cycle sequences, and randomized play against a
// step-count based reference model.
module tb_arrow_scroll_scheduler;
  localparam int ST = 4;
  localparam int SL = 40;
  localparam int HS = 8;

  logic        clock = 1'b0;
  logic        reset, start, p1_press, p2_press;
  logic [2:0]  p1_code, p2_code, song_data;
  logic [7:0]  song_addr;
  logic [77:0] p1_arrow_array, p2_arrow_array;
  logic [1:0]  p1_indicator, p2_indicator;
  logic [15:0] p1_score, p2_score;
  logic        busy, done;
  logic [2:0]  rom [0:255];

  int errors = 0;
  int checks = 0;

  // reference model state: playfield as plain slot arrays, time as cycles since start
  int m_slot [2][26];
  int m_ind [2], m_hold [2], m_score [2];
  bit m_active, m_done;
  int m_cyc, m_steps;

  always #5 clock = ~clock;
  always @(posedge clock) song_data <= rom[song_addr];

  arrow_scroll_scheduler #(.STEP_TICKS(ST), .SONG_LEN(SL), .HOLD_STEPS(HS)) dut (
    .clock(clock), .reset(reset), .start(start),
    .song_addr(song_addr), .song_data(song_data),
    .p1_press(p1_press), .p1_code(p1_code), .p2_press(p2_press), .p2_code(p2_code),
    .p1_arrow_array(p1_arrow_array), .p2_arrow_array(p2_arrow_array),
    .p1_indicator(p1_indicator), .p2_indicator(p2_indicator),
    .p1_score(p1_score), .p2_score(p2_score), .busy(busy), .done(done));

  task automatic check(input string name, input logic [77:0] act, input logic [77:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [77:0] pack(input int p);
    logic [77:0] v;
    v = '0;
    for (int k = 0; k < 26; k++) v[3*k +: 3] = 3'(m_slot[p][k]);
    return v;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 26; k++) m_slot[p][k] = 0;
      m_ind[p] = 0; m_hold[p] = 0; m_score[p] = 0;
    end
  endtask

  task automatic player_model(input int p, input bit press, input int code, input bit is_step, input int din);
    int  order [4] = '{24, 23, 25, 22};
    int  hit;
    bit  judged, miss;
    hit    = -1;
    judged = press && (code != 0);
    if (judged)
      for (int i = 0; i < 4; i++)
        if (hit < 0 && m_slot[p][order[i]] == code) hit = order[i];
    if (hit >= 0) m_slot[p][hit] = 0;
    miss = 1'b0;
    if (is_step) begin
      miss = (m_slot[p][25] != 0);
      for (int k = 25; k > 0; k--) m_slot[p][k] = m_slot[p][k-1];
      m_slot[p][0] = din;
    end
    if (judged) begin
      m_hold[p] = HS;
      if (hit < 0) m_ind[p] = 1;
      else if (hit == 24 || hit == 23) begin
        m_ind[p] = 3; m_score[p] = (m_score[p] + 2 > 65535) ? 65535 : m_score[p] + 2;
      end else begin
        m_ind[p] = 2; m_score[p] = (m_score[p] + 1 > 65535) ? 65535 : m_score[p] + 1;
      end
    end else if (miss) begin
      m_ind[p] = 1; m_hold[p] = HS;
    end else if (is_step && m_hold[p] > 0) begin
      m_hold[p]--;
      if (m_hold[p] == 0) m_ind[p] = 0;
    end
  endtask

  // advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    bit is_step;
    int k, din;
    if (reset) begin
      model_clear(); m_active = 0; m_done = 0; m_steps = 0; m_cyc = 0;
    end else if (!m_active && start) begin
      model_clear(); m_active = 1; m_done = 0; m_cyc = 0; m_steps = 0;
    end else if (m_active) begin
      m_cyc++;
      is_step = (m_cyc % ST) == 0;
      k   = m_cyc / ST - 1;
      din = (k < SL) ? int'(rom[k]) : 0;
      player_model(0, p1_press, int'(p1_code), is_step, din);
      player_model(1, p2_press, int'(p2_code), is_step, din);
      if (is_step) begin
        m_steps = k + 1;
        if (k == SL + 25) begin m_active = 0; m_done = 1; end
      end
    end
  endtask

  task automatic compare_all();
    int a;
    a = (m_steps > SL) ? SL : m_steps;
    check("p1_array", p1_arrow_array, pack(0));
    check("p2_array", p2_arrow_array, pack(1));
    check("p1_indicator", 78'(p1_indicator), 78'(m_ind[0]));
    check("p2_indicator", 78'(p2_indicator), 78'(m_ind[1]));
    check("p1_score", 78'(p1_score), 78'(m_score[0]));
    check("p2_score", 78'(p2_score), 78'(m_score[1]));
    check("busy", 78'(busy), 78'(m_active));
    check("done", 78'(done), 78'(m_done));
    check("song_addr", 78'(song_addr), 78'(a[7:0]));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic idle_ticks(input int n);
    start = 1'b0; reset = 1'b0; p1_press = 1'b0; p2_press = 1'b0;
    p1_code = 3'b000; p2_code = 3'b000;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_and_start();
    for (int i = 0; i < 256; i++) rom[i] = 3'b000;
    rom[0] = 3'b001;
    reset = 1'b1; tick(); reset = 1'b0;
    idle_ticks(1);
    start = 1'b1; tick(); start = 1'b0;
  endtask

  typedef struct {
    int          s;
    logic [2:0]  code;
    logic [1:0]  exp_ind;
    logic [15:0] exp_score;
    logic [2:0]  exp_slot;
  } jvec_t;

  jvec_t jt [7];

  initial begin
    reset = 1'b1; start = 1'b0; p1_press = 1'b0; p2_press = 1'b0;
    p1_code = 3'b000; p2_code = 3'b000;
    for (int i = 0; i < 256; i++) rom[i] = 3'b000;
    model_clear(); m_active = 0; m_done = 0; m_cyc = 0; m_steps = 0;

    tick();
    check("reset_busy", 78'(busy), 78'(1'b0));
    check("reset_array", p1_arrow_array, 78'(0));

    jt[0] = '{24, 3'b001, 2'b11, 16'd2, 3'b000};
    jt[1] = '{23, 3'b001, 2'b11, 16'd2, 3'b000};
    jt[2] = '{25, 3'b001, 2'b10, 16'd1, 3'b000};
    jt[3] = '{22, 3'b001, 2'b10, 16'd1, 3'b000};
    jt[4] = '{24, 3'b100, 2'b01, 16'd0, 3'b001};
    jt[5] = '{21, 3'b001, 2'b01, 16'd0, 3'b001};
    jt[6] = '{24, 3'b000, 2'b00, 16'd0, 3'b001};

    // judgment table: single up-arrow parked at slot s, p1 presses between steps
    for (int i = 0; i < 7; i++) begin
      reset_and_start();
      idle_ticks(ST * (jt[i].s + 1));
      p1_press = 1'b1; p1_code = jt[i].code;
      tick();
      p1_press = 1'b0;
      check($sformatf("tbl%0d_p1_ind", i), 78'(p1_indicator), 78'(jt[i].exp_ind));
      check($sformatf("tbl%0d_p1_score", i), 78'(p1_score), 78'(jt[i].exp_score));
      check($sformatf("tbl%0d_p1_slot", i), 78'(p1_arrow_array[3*jt[i].s +: 3]), 78'(jt[i].exp_slot));
      check($sformatf("tbl%0d_p2_slot", i), 78'(p2_arrow_array[3*jt[i].s +: 3]), 78'(3'b001));
      check($sformatf("tbl%0d_p2_ind", i), 78'(p2_indicator), 78'(2'b00));
    end

    // first-step latency, bottom slot, miss and indicator hold
    reset_and_start();
    idle_ticks(ST - 1);
    check("pre_step_slot0", 78'(p1_arrow_array[2:0]), 78'(3'b000));
    idle_ticks(1);
    check("step0_slot0", 78'(p1_arrow_array[2:0]), 78'(3'b001));
    check("step0_addr", 78'(song_addr), 78'(8'd1));
    idle_ticks(ST * 25);
    check("slot25_arrow", 78'(p1_arrow_array[77:75]), 78'(3'b001));
    check("slot25_ind", 78'(p1_indicator), 78'(2'b00));
    idle_ticks(ST);
    check("miss_p1_ind", 78'(p1_indicator), 78'(2'b01));
    check("miss_p2_ind", 78'(p2_indicator), 78'(2'b01));
    check("miss_array", p1_arrow_array, 78'(0));
    idle_ticks(ST * (HS - 1));
    check("hold_still_on", 78'(p1_indicator), 78'(2'b01));
    idle_ticks(ST);
    check("hold_expired", 78'(p1_indicator), 78'(2'b00));

    // press on the same edge as a step, arrow at slot 23 before the shift
    reset_and_start();
    idle_ticks(ST * 24 + ST - 1);
    p1_press = 1'b1; p1_code = 3'b001;
    tick();
    p1_press = 1'b0;
    check("coinc_ind", 78'(p1_indicator), 78'(2'b11));
    check("coinc_score", 78'(p1_score), 78'(16'd2));
    check("coinc_p1_slot24", 78'(p1_arrow_array[74:72]), 78'(3'b000));
    check("coinc_p2_slot24", 78'(p2_arrow_array[74:72]), 78'(3'b001));

    // full song to DONE, with an ignored start pulse mid-run
    reset_and_start();
    idle_ticks(40);
    start = 1'b1; tick(); start = 1'b0;
    idle_ticks(ST * (SL + 26) - 41 - 1);
    check("before_done_busy", 78'(busy), 78'(1'b1));
    check("before_done_done", 78'(done), 78'(1'b0));
    idle_ticks(1);
    check("done_flag", 78'(done), 78'(1'b1));
    check("done_busy", 78'(busy), 78'(1'b0));
    check("done_array", p1_arrow_array | p2_arrow_array, 78'(0));
    check("done_addr", 78'(song_addr), 78'(8'(SL)));

    // reset in the middle of a run
    reset_and_start();
    idle_ticks(ST * 24 + 1);
    p1_press = 1'b1; p1_code = 3'b001; tick(); p1_press = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_busy", 78'(busy), 78'(1'b0));
    check("midrst_score", 78'(p1_score), 78'(16'd0));
    check("midrst_ind", 78'(p1_indicator), 78'(2'b00));
    check("midrst_addr", 78'(song_addr), 78'(8'd0));

    // randomized play against the model
    for (int c = 0; c < 6000; c++) begin
      if (!m_active && $urandom_range(0, 3) == 0)
        for (int i = 0; i < SL; i++) begin
          case ($urandom_range(0, 9))
            0: rom[i] = 3'b001;
            1: rom[i] = 3'b010;
            2: rom[i] = 3'b011;
            3: rom[i] = 3'b100;
            4: rom[i] = 3'b110;
            default: rom[i] = 3'b000;
          endcase
        end
      reset    = ($urandom_range(0, 1499) == 0);
      start    = ($urandom_range(0, 29) == 0);
      p1_press = ($urandom_range(0, 2) == 0);
      p2_press = ($urandom_range(0, 2) == 0);
      p1_code  = ($urandom_range(0, 1) == 0) ? 3'(m_slot[0][$urandom_range(22, 25)]) : 3'($urandom_range(0, 7));
      p2_code  = ($urandom_range(0, 1) == 0) ? 3'(m_slot[1][$urandom_range(22, 25)]) : 3'($urandom_range(0, 7));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arrow_scroll_scheduler.md
# arrow_scroll_scheduler

- Sequences the two-player arrow playfield.
- Fetches one chart step per scroll tick from the song ROM and shifts it into both players' 26-slot arrow arrays.
- Judges button presses against the hit window and drives the p1/p2 indicator codes and scores.
- Sits upstream of the VGA index lookup, which renders p1_arrow_array, p2_arrow_array, p1_indicator and p2_indicator.

## Interface
Parameters:
- STEP_TICKS, 833333: clock cycles per scroll step (≥2).
- SONG_LEN, 256: number of chart steps in the ROM (≤256).
- HOLD_STEPS, 8: scroll steps an indicator code stays visible.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- song_addr  out  8  chart ROM address; ROM output is registered, 1-cycle latency.
- song_data  in  3  arrow code at song_addr: up 001, left 010, down 011, right 100, shake 110, none 000.
- p1_press, p2_press  in  1  one-cycle press strobe per player.
- p1_code, p2_code  in  3  lane code accompanying the strobe.
- p1_arrow_array, p2_arrow_array  out  78  slot k = bits [3k+2:3k]; slot 0 is the top of the screen.
- p1_indicator, p2_indicator  out  2  11 excellent, 10 good, 01 bad, 00 blank.
- p1_score, p2_score  out  16  saturating scores.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on start:
  - clear both arrays, scores and indicators;
  - set step index to 0 and tick counter to 0.
- song_addr = step index[7:0] at all times.
- Tick counter counts 0..STEP_TICKS-1. Terminal count is a "step".
- RUN step:
  - every slot k (1..25) takes slot k-1; slot 0 takes song_data;
  - the step index increments;
  - the old slot 25 is discarded;
  - when the step index becomes SONG_LEN, go to DRAIN.
- DRAIN step: same shift, with 000 loaded into slot 0. After 26 DRAIN steps, go to DONE.
- DONE: arrays all zero, scores held, done=1.
  - start → RUN, behaving exactly as IDLE → RUN.
- Identical chart data enters both arrays. Hit-clears are per player, so the arrays diverge.
- Press judgment (RUN/DRAIN only; ignored if code=000 or in IDLE/DONE):
  - Excellent tier is slots 24, 23. Good tier is slots 25, 22.
  - Search the excellent tier first, then the good tier. Within a tier, take the higher slot first.
  - The first slot whose value equals the code is the match.
  - Excellent: indicator ← 11, score += 2, matched slot ← 000.
  - Good: indicator ← 10, score += 1, matched slot ← 000.
  - No match: indicator ← 01, no score change.
  - Score saturates at 16'hFFFF.
- Miss: a step shifts a nonzero slot 25 out of a player's array → that player's indicator ← 01.
- Indicator hold:
  - any judgment or miss loads the player's hold counter with HOLD_STEPS;
  - each step decrements it;
  - reaching 0 sets the indicator to 00;
  - a new judgment restarts the count.
- Press and step in the same cycle:
  - judge against the pre-shift array;
  - clear the matched slot, then shift, so the cleared value lands in slot k+1;
  - press indicator outcome overrides a simultaneous miss.
- p1 and p2 logic are fully independent; simultaneous presses are both processed.

## Timing
- All outputs registered.
- Reset values: arrays 0, indicators 00, scores 0, song_addr 0, busy 0, done 0, state IDLE.
- start sampled at edge N → busy=1 at N+1. The first step occurs STEP_TICKS cycles after entering RUN.
- Step on the cycle-N edge → arrays and song_addr new at N+1.
- ROM data for the new address is valid by N+2. This is always before the next step, since STEP_TICKS ≥ 2.
- Press at edge N → indicator, score and slot clear visible at N+1.
- The last DRAIN step moves to DONE on the same edge.
- Reset mid-RUN returns to IDLE on the next edge and clears everything. Any in-progress step is lost.
- start during RUN/DRAIN is ignored.

## Test plan
- Reset, STEP_TICKS=4, ROM[0]=001, rest 000, start → step 0 lands at cycle 5 (slot 0=001); slot 25=001 after 25 further steps (100 cycles).
- With that arrow at slot 24, p1_press with code 001 → p1_indicator=11, p1_score=2, p1 slot 24=000; p2 array unchanged.
- Arrow at slot 22, press matching code → indicator 10, score 1. Press code 100 with no match → indicator 01, score unchanged.
- Never press: arrow leaves slot 25 → indicator 01 on that step; returns to 00 exactly HOLD_STEPS steps later.
- Press coincident with step, arrow at slot 23 → excellent judged; post-shift slot 24 is 000.
- SONG_LEN=4 → after 4 RUN steps + 26 DRAIN steps, done=1 and arrays are zero. Reset asserted mid-RUN → all outputs zero next cycle, state IDLE.
